// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: frame/packet sizing defaults and the Tx arbiter state type.
package UartGlobalPkg;

  localparam int DATA_WIDTH       = 8;
  localparam int NO_OF_PACKETS    = 50;
  localparam int UART_ARB_MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } uart_arb_state_e;

  // Next requester after id, wrapping explicitly so non-power-of-2 counts work.
  function automatic int rr_next(input int id, input int n);
    return (id >= n - 1) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first request at or after ptr, scanning upward with wrap.
module uart_rr_pick
  import UartGlobalPkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx
);

  always_comb begin : pick
    logic [IW:0]   sum;
    logic [IW-1:0] k;
    onehot = '0;
    idx    = '0;
    sum    = '0;
    k      = '0;
    // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (IW + 1)'(off);
      if (sum >= (IW + 1)'(NUM_REQ)) sum = sum - (IW + 1)'(NUM_REQ);
      k = sum[IW-1:0];
      if (req[k]) begin
        onehot    = '0;
        onehot[k] = 1'b1;
        idx       = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular owner of the single UART Tx serializer.
// Optional stall watchdog with forced release: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import UartGlobalPkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = UartGlobalPkg::DATA_WIDTH,
  parameter int MAX_BEATS  = UartGlobalPkg::NO_OF_PACKETS,
  parameter int TIMEOUT    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               tx_valid,
  output logic [DATA_WIDTH-1:0]              tx_data,
  input  logic                               tx_ready,
  output logic                               grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic [$clog2(MAX_BEATS+1)-1:0]     beat_count,
  output logic                               trunc_err,
  output logic                               timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BEATS + 1);

  uart_arb_state_e     state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  logic                pick_any;
  logic                owner_valid;
  logic                owner_last;
  logic                beat;
  logic                at_limit;
  logic                grant_end;
  logic                stall_expire;
  logic [IW-1:0]       next_ptr;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign pick_any    = |pick_oh;
  assign owner_valid = req_valid[grant_id];
  assign owner_last  = req_last[grant_id];
  assign tx_valid    = (state == XFER) && owner_valid;
  assign tx_data     = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign beat        = tx_valid && tx_ready;
  assign at_limit    = (beat_count == BW'(MAX_BEATS - 1));
  assign grant_end   = beat && (owner_last || at_limit);
  assign next_ptr    = IW'(rr_next(int'(grant_id), NUM_REQ));

  always_comb begin
    req_ready = '0;
    if (state == XFER) req_ready[grant_id] = tx_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_count  <= '0;
      trunc_err   <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state       <= XFER;
            grant_valid <= 1'b1;
            grant_id    <= pick_idx;
            beat_count  <= '0;
          end
        end
        XFER: begin
          if (beat && (beat_count != BW'(MAX_BEATS))) beat_count <= beat_count + BW'(1);
          if (grant_end || stall_expire) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
            trunc_err   <= grant_end && at_limit && !owner_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_cnt;

  // Only an owner with nothing to send counts as a stall; serializer backpressure does not.
  assign stall_expire = (state == XFER) && !owner_valid && (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= stall_expire;
      if ((state != XFER) || owner_valid || stall_expire) stall_cnt <= '0;
      else                                                stall_cnt <= stall_cnt + SW'(1);
    end
  end
`else
  assign stall_expire = 1'b0;
  // Without force-release the stall limit is meaningless; this is constant low.
  assign timeout_err  = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 50;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_ready;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic [5:0]      beat_count;
  logic            trunc_err;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .beat_count  (beat_count),
    .trunc_err   (trunc_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]         = v;
    req_data[i*DW +: DW] = d;
    req_last[i]          = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    tick();
    tick();
    checks++; if (grant_valid !== 1'b0) begin errors++; $error("FAIL rst_grant_valid observed=%0h expected=0", grant_valid); end
    checks++; if (grant_id !== 2'd0) begin errors++; $error("FAIL rst_grant_id observed=%0h expected=0", grant_id); end
    checks++; if (beat_count !== 6'd0) begin errors++; $error("FAIL rst_beat_count observed=%0h expected=0", beat_count); end
    checks++; if (trunc_err !== 1'b0) begin errors++; $error("FAIL rst_trunc_err observed=%0h expected=0", trunc_err); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $error("FAIL rst_timeout_err observed=%0h expected=0", timeout_err); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $error("FAIL rst_tx_valid observed=%0h expected=0", tx_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $error("FAIL rst_req_ready observed=%0h expected=0", req_ready); end
    reset = 1'b0;

    tx_ready = 1'b1;
    set_req(2, 1'b1, 8'hA5, 1'b0);
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $error("FAIL single_idle_tx_valid observed=%0h expected=0", tx_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $error("FAIL single_idle_req_ready observed=%0h expected=0", req_ready); end
    tick();
    checks++; if (grant_valid !== 1'b1) begin errors++; $error("FAIL single_grant_valid observed=%0h expected=1", grant_valid); end
    checks++; if (grant_id !== 2'd2) begin errors++; $error("FAIL single_grant_id observed=%0h expected=2", grant_id); end
    checks++; if (tx_valid !== 1'b1) begin errors++; $error("FAIL single_tx_valid observed=%0h expected=1", tx_valid); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $error("FAIL single_tx_data0 observed=%0h expected=a5", tx_data); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $error("FAIL single_req_ready observed=%0h expected=4", req_ready); end
    checks++; if (beat_count !== 6'd0) begin errors++; $error("FAIL single_beat0 observed=%0h expected=0", beat_count); end
    tick();
    set_req(2, 1'b1, 8'h3C, 1'b1);
    #1;
    checks++; if (tx_data !== 8'h3C) begin errors++; $error("FAIL single_tx_data1 observed=%0h expected=3c", tx_data); end
    checks++; if (beat_count !== 6'd1) begin errors++; $error("FAIL single_beat1 observed=%0h expected=1", beat_count); end
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $error("FAIL single_end_grant_valid observed=%0h expected=0", grant_valid); end
    checks++; if (beat_count !== 6'd2) begin errors++; $error("FAIL single_end_beat observed=%0h expected=2", beat_count); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $error("FAIL single_end_tx_valid observed=%0h expected=0", tx_valid); end

    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
    #1;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (grant_valid !== 1'b1) begin errors++; $error("FAIL rr_grant_valid observed=%0h expected=1", grant_valid); end
      checks++; if (int'(grant_id) !== ((3 + k) % 4)) begin errors++; $error("FAIL rr_grant_id observed=%0h expected=%0h", grant_id, (3 + k) % 4); end
      checks++; if (int'(tx_data) !== ('h10 + ((3 + k) % 4))) begin errors++; $error("FAIL rr_tx_data observed=%0h expected=%0h", tx_data, 'h10 + ((3 + k) % 4)); end
      tick();
      checks++; if (grant_valid !== 1'b0) begin errors++; $error("FAIL rr_gap_grant_valid observed=%0h expected=0", grant_valid); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $error("FAIL rr_gap_tx_valid observed=%0h expected=0", tx_valid); end
      if (k < 4) tick();
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 1'b0);

    set_req(1, 1'b1, 8'h00, 1'b0);
    set_req(2, 1'b1, 8'h77, 1'b1);
    #1;
    tick();
    checks++; if (grant_id !== 2'd1) begin errors++; $error("FAIL trunc_grant_id observed=%0h expected=1", grant_id); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $error("FAIL trunc_req_ready observed=%0h expected=2", req_ready); end
    for (int b = 0; b < MB; b++) begin
      set_req(1, 1'b1, 8'(b), 1'b0);
      #1;
      checks++; if (int'(tx_data) !== b) begin errors++; $error("FAIL trunc_tx_data observed=%0h expected=%0h", tx_data, b); end
      checks++; if (int'(beat_count) !== b) begin errors++; $error("FAIL trunc_beat observed=%0h expected=%0h", beat_count, b); end
      tick();
    end
    checks++; if (grant_valid !== 1'b0) begin errors++; $error("FAIL trunc_end_grant_valid observed=%0h expected=0", grant_valid); end
    checks++; if (beat_count !== 6'd50) begin errors++; $error("FAIL trunc_end_beat observed=%0h expected=32", beat_count); end
    checks++; if (trunc_err !== 1'b1) begin errors++; $error("FAIL trunc_err_pulse observed=%0h expected=1", trunc_err); end
    tick();
    checks++; if (grant_id !== 2'd2) begin errors++; $error("FAIL trunc_next_grant_id observed=%0h expected=2", grant_id); end
    checks++; if (trunc_err !== 1'b0) begin errors++; $error("FAIL trunc_err_clear observed=%0h expected=0", trunc_err); end
    checks++; if (beat_count !== 6'd0) begin errors++; $error("FAIL trunc_next_beat observed=%0h expected=0", beat_count); end
    checks++; if (tx_data !== 8'h77) begin errors++; $error("FAIL trunc_next_tx_data observed=%0h expected=77", tx_data); end
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    set_req(2, 1'b0, 8'h00, 1'b0);
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $error("FAIL trunc_last_grant_valid observed=%0h expected=0", grant_valid); end
    checks++; if (trunc_err !== 1'b0) begin errors++; $error("FAIL trunc_last_no_err observed=%0h expected=0", trunc_err); end
    checks++; if (beat_count !== 6'd1) begin errors++; $error("FAIL trunc_last_beat observed=%0h expected=1", beat_count); end

    set_req(0, 1'b1, 8'hD0, 1'b0);
    set_req(1, 1'b1, 8'hEE, 1'b0);
    tx_ready = 1'b1;
    #1;
    tick();
    checks++; if (grant_id !== 2'd0) begin errors++; $error("FAIL bp_grant_id observed=%0h expected=0", grant_id); end
    checks++; if (tx_data !== 8'hD0) begin errors++; $error("FAIL bp_tx_data0 observed=%0h expected=d0", tx_data); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $error("FAIL bp_req_ready0 observed=%0h expected=1", req_ready); end
    checks++; if (beat_count !== 6'd0) begin errors++; $error("FAIL bp_beat0 observed=%0h expected=0", beat_count); end
    tick();
    set_req(0, 1'b1, 8'hD1, 1'b0);
    tx_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $error("FAIL bp_stall_req_ready observed=%0h expected=0", req_ready); end
    checks++; if (tx_valid !== 1'b1) begin errors++; $error("FAIL bp_stall_tx_valid observed=%0h expected=1", tx_valid); end
    checks++; if (tx_data !== 8'hD1) begin errors++; $error("FAIL bp_stall_tx_data observed=%0h expected=d1", tx_data); end
    checks++; if (beat_count !== 6'd1) begin errors++; $error("FAIL bp_stall_beat observed=%0h expected=1", beat_count); end
    tick();
    checks++; if (beat_count !== 6'd1) begin errors++; $error("FAIL bp_stall2_beat observed=%0h expected=1", beat_count); end
    checks++; if (req_ready !== 4'b0) begin errors++; $error("FAIL bp_stall2_req_ready observed=%0h expected=0", req_ready); end
    tick();
    tx_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $error("FAIL bp_resume_req_ready observed=%0h expected=1", req_ready); end
    checks++; if (beat_count !== 6'd1) begin errors++; $error("FAIL bp_resume_beat observed=%0h expected=1", beat_count); end
    checks++; if (tx_data !== 8'hD1) begin errors++; $error("FAIL bp_resume_tx_data observed=%0h expected=d1", tx_data); end
    tick();
    set_req(0, 1'b1, 8'hD2, 1'b1);
    #1;
    checks++; if (tx_data !== 8'hD2) begin errors++; $error("FAIL bp_tx_data2 observed=%0h expected=d2", tx_data); end
    checks++; if (beat_count !== 6'd2) begin errors++; $error("FAIL bp_beat2 observed=%0h expected=2", beat_count); end
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $error("FAIL bp_end_grant_valid observed=%0h expected=0", grant_valid); end
    checks++; if (beat_count !== 6'd3) begin errors++; $error("FAIL bp_end_beat observed=%0h expected=3", beat_count); end
    checks++; if (trunc_err !== 1'b0) begin errors++; $error("FAIL bp_end_trunc observed=%0h expected=0", trunc_err); end

    set_req(3, 1'b1, 8'h30, 1'b0);
    #1;
    tick();
    checks++; if (grant_id !== 2'd3) begin errors++; $error("FAIL rstmid_grant_id observed=%0h expected=3", grant_id); end
    for (int b = 0; b < 3; b++) begin
      set_req(3, 1'b1, 8'(8'h30 + b), 1'b0);
      #1;
      checks++; if (int'(tx_data) !== ('h30 + b)) begin errors++; $error("FAIL rstmid_tx_data observed=%0h expected=%0h", tx_data, 'h30 + b); end
      tick();
    end
    set_req(3, 1'b0, 8'h33, 1'b0);
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $error("FAIL rstmid_gap_tx_valid observed=%0h expected=0", tx_valid); end
    tick();
    checks++; if (beat_count !== 6'd3) begin errors++; $error("FAIL rstmid_gap_beat observed=%0h expected=3", beat_count); end
    checks++; if (grant_valid !== 1'b1) begin errors++; $error("FAIL rstmid_gap_grant_valid observed=%0h expected=1", grant_valid); end
    set_req(3, 1'b1, 8'h33, 1'b0);
    reset = 1'b1;
    #1;
    tick();
    checks++; if (grant_valid !== 1'b0) begin errors++; $error("FAIL rstmid_grant_valid observed=%0h expected=0", grant_valid); end
    checks++; if (grant_id !== 2'd0) begin errors++; $error("FAIL rstmid_grant_id0 observed=%0h expected=0", grant_id); end
    checks++; if (beat_count !== 6'd0) begin errors++; $error("FAIL rstmid_beat observed=%0h expected=0", beat_count); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $error("FAIL rstmid_tx_valid observed=%0h expected=0", tx_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $error("FAIL rstmid_req_ready observed=%0h expected=0", req_ready); end
    checks++; if (trunc_err !== 1'b0) begin errors++; $error("FAIL rstmid_trunc observed=%0h expected=0", trunc_err); end
    reset = 1'b0;
    set_req(0, 1'b1, 8'h40, 1'b1);
    #1;
    tick();
    checks++; if (grant_id !== 2'd0) begin errors++; $error("FAIL rstmid_ptr_grant_id observed=%0h expected=0", grant_id); end
    checks++; if (tx_data !== 8'h40) begin errors++; $error("FAIL rstmid_ptr_tx_data observed=%0h expected=40", tx_data); end
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(3, 1'b0, 8'h00, 1'b0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 8'h50, 1'b0);
    set_req(1, 1'b1, 8'h60, 1'b1);
    #1;
    tick();
    checks++; if (grant_id !== 2'd0) begin errors++; $error("FAIL stall_grant_id observed=%0h expected=0", grant_id); end
    tick();
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    #1;
    checks++; if (beat_count !== 6'd2) begin errors++; $error("FAIL stall_beat observed=%0h expected=2", beat_count); end
`ifdef UART_ARB_TIMEOUT_EN
    for (int s = 0; s < TO; s++) begin
      checks++; if (grant_valid !== 1'b1) begin errors++; $error("FAIL to_hold_grant_valid observed=%0h expected=1", grant_valid); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $error("FAIL to_hold_timeout_err observed=%0h expected=0", timeout_err); end
      tick();
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $error("FAIL to_timeout_err observed=%0h expected=1", timeout_err); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $error("FAIL to_grant_valid observed=%0h expected=0", grant_valid); end
    checks++; if (trunc_err !== 1'b0) begin errors++; $error("FAIL to_trunc observed=%0h expected=0", trunc_err); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $error("FAIL to_timeout_clear observed=%0h expected=0", timeout_err); end
    checks++; if (grant_id !== 2'd1) begin errors++; $error("FAIL to_next_grant_id observed=%0h expected=1", grant_id); end
    checks++; if (grant_valid !== 1'b1) begin errors++; $error("FAIL to_next_grant_valid observed=%0h expected=1", grant_valid); end
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
`else
    repeat (20) tick();
    checks++; if (grant_valid !== 1'b1) begin errors++; $error("FAIL hold_grant_valid observed=%0h expected=1", grant_valid); end
    checks++; if (grant_id !== 2'd0) begin errors++; $error("FAIL hold_grant_id observed=%0h expected=0", grant_id); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $error("FAIL hold_timeout_err observed=%0h expected=0", timeout_err); end
    checks++; if (beat_count !== 6'd2) begin errors++; $error("FAIL hold_beat observed=%0h expected=2", beat_count); end
    set_req(0, 1'b1, 8'h51, 1'b1);
    #1;
    checks++; if (tx_data !== 8'h51) begin errors++; $error("FAIL hold_tx_data observed=%0h expected=51", tx_data); end
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $error("FAIL hold_end_grant_valid observed=%0h expected=0", grant_valid); end
    checks++; if (beat_count !== 6'd3) begin errors++; $error("FAIL hold_end_beat observed=%0h expected=3", beat_count); end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
